// File: rtl/picorv_bus_pkg.sv
// Shared types for the PicoRV32 native-bus arbiter: FSM states, the latched
// downstream request and the arbitration mode encodings.
package picorv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/picorv_rr_pick.sv
// Two-way winner select. Round-robin favours the requester that did not own
// the last grant; fixed mode always favours m0.
module picorv_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       fixed_i,
    output logic       any_o,
    output logic       pick_o
);

    always_comb begin
        any_o  = |valid_i;
        pick_o = 1'b0;
        if (valid_i == 2'b11) begin
            pick_o = fixed_i ? 1'b0 : ~last_i;
        end else if (valid_i == 2'b10) begin
            pick_o = 1'b1;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one PicoRV32 native memory port between two requesters, one
// transaction at a time, with a watchdog that force-completes stuck accesses.
module picorv32_mem_arbiter
    import picorv_bus_pkg::*;
#(
    parameter int          ARB_MODE       = ARB_RR,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        m0_valid_i,
    input  logic        m0_instr_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_valid_i,
    input  logic        m1_instr_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        grant_id_o,
    output logic        timeout_err_o
);

    localparam int             WDW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic           WD_EN   = (TIMEOUT_CYCLES > 0);

    arb_state_e     state_q;
    mem_req_t       req_q, req_d;
    logic           mem_valid_q;
    logic           grant_q;
    logic           terr_q;
    logic           drop_q;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic        any_req, pick;
    logic        wd_expire, done, gvalid, pulse;
    logic [31:0] rsp_rdata;

    picorv_rr_pick u_pick (
        .valid_i ({m1_valid_i, m0_valid_i}),
        .last_i  (grant_q),
        .fixed_i (ARB_MODE == ARB_FIXED),
        .any_o   (any_req),
        .pick_o  (pick)
    );

    always_comb begin
        if (pick) begin
            req_d = '{instr: m1_instr_i, addr: m1_addr_i, wdata: m1_wdata_i, wstrb: m1_wstrb_i};
        end else begin
            req_d = '{instr: m0_instr_i, addr: m0_addr_i, wdata: m0_wdata_i, wstrb: m0_wstrb_i};
        end
        wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    end

    // mem_ready beats a coincident watchdog expiry because rsp_rdata and the
    // sticky error both key off mem_ready_i first.
    assign wd_expire = WD_EN && (wdog_q == WD_LAST);
    assign done      = (state_q == ST_BUSY) && (mem_ready_i || wd_expire);
    assign gvalid    = grant_q ? m1_valid_i : m0_valid_i;
    assign pulse     = done && gvalid && !drop_q && !reset_i;
    assign rsp_rdata = mem_ready_i ? mem_rdata_i : ERR_RDATA;

    assign m0_ready_o = pulse && !grant_q;
    assign m1_ready_o = pulse && grant_q;
    assign m0_rdata_o = m0_ready_o ? rsp_rdata : 32'h0;
    assign m1_rdata_o = m1_ready_o ? rsp_rdata : 32'h0;

    assign mem_valid_o   = mem_valid_q;
    assign mem_instr_o   = req_q.instr;
    assign mem_addr_o    = req_q.addr;
    assign mem_wdata_o   = req_q.wdata;
    assign mem_wstrb_o   = req_q.wstrb;
    assign grant_id_o    = grant_q;
    assign timeout_err_o = terr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            mem_valid_q <= 1'b0;
            grant_q     <= 1'b1;
            terr_q      <= 1'b0;
            drop_q      <= 1'b0;
            wdog_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        req_q       <= req_d;
                        mem_valid_q <= 1'b1;
                        grant_q     <= pick;
                        wdog_q      <= '0;
                        drop_q      <= 1'b0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    wdog_q <= wdog_d;
                    // A requester that abandons its request never gets the pulse,
                    // even if it re-asserts valid before the access finishes.
                    if (!gvalid) drop_q <= 1'b1;
                    if (done) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ST_RECOVER;
                        if (!mem_ready_i) terr_q <= 1'b1;
                    end
                end
                ST_RECOVER: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: reset state, table of single transactions,
// directed corner sequences, then randomized traffic against a reference model.
module tb_picorv32_mem_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        mem_ready = 0;
    logic [31:0] mem_rdata = 0;

    logic        a_m0_ready, a_m1_ready, a_mem_valid, a_mem_instr, a_grant, a_terr;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_m0_ready, b_m1_ready, b_mem_valid, b_mem_instr, b_grant, b_terr;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;

    picorv32_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .m0_valid_i(m0_valid), .m0_instr_i(m0_instr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wstrb_i(m0_wstrb), .m0_ready_o(a_m0_ready), .m0_rdata_o(a_m0_rdata),
        .m1_valid_i(m1_valid), .m1_instr_i(m1_instr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wstrb_i(m1_wstrb), .m1_ready_o(a_m1_ready), .m1_rdata_o(a_m1_rdata),
        .mem_valid_o(a_mem_valid), .mem_instr_o(a_mem_instr), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_wstrb_o(a_mem_wstrb), .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata), .grant_id_o(a_grant), .timeout_err_o(a_terr)
    );

    picorv32_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .m0_valid_i(m0_valid), .m0_instr_i(m0_instr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wstrb_i(m0_wstrb), .m0_ready_o(b_m0_ready), .m0_rdata_o(b_m0_rdata),
        .m1_valid_i(m1_valid), .m1_instr_i(m1_instr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wstrb_i(m1_wstrb), .m1_ready_o(b_m1_ready), .m1_rdata_o(b_m1_rdata),
        .mem_valid_o(b_mem_valid), .mem_instr_o(b_mem_instr), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_wstrb_o(b_mem_wstrb), .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata), .grant_id_o(b_grant), .timeout_err_o(b_terr)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no completion within cycle budget", name);
    endtask

    // Downstream slave: mem_ready in BUSY cycle index rsp_lat (0 = first cycle
    // mem_valid is seen); random rdata on every other cycle.
    int          rsp_lat  = 100;
    logic [31:0] rsp_data = 0;
    int          bcnt     = 0;
    initial begin
        logic nxt;
        forever begin
            @(negedge clk);
            if (a_mem_valid && !reset) begin
                nxt = (bcnt + 1 == rsp_lat);
                bcnt++;
            end else begin
                nxt  = 1'b0;
                bcnt = 0;
            end
            @(posedge clk);
            #1;
            mem_ready = nxt;
            mem_rdata = nxt ? rsp_data : $urandom;
        end
    end

    // Always-on properties: exclusive ready, >=2 idle cycles between accesses,
    // request fields stable while mem_valid is held.
    initial begin
        logic        pv = 0, pins = 0;
        logic [31:0] paddr = 0, pwd = 0;
        logic [3:0]  pws = 0;
        int          gap = 2;
        forever begin
            @(negedge clk);
            chk("excl_ready_a", a_m0_ready & a_m1_ready, 0);
            chk("excl_ready_b", b_m0_ready & b_m1_ready, 0);
            if (reset) begin
                gap = 2;
            end else begin
                if (a_mem_valid && !pv) chk("idle_gap", gap >= 2, 1);
                if (a_mem_valid && pv) begin
                    chk("stable_addr", a_mem_addr, paddr);
                    chk("stable_wdata", a_mem_wdata, pwd);
                    chk("stable_wstrb", a_mem_wstrb, pws);
                    chk("stable_instr", a_mem_instr, pins);
                end
                gap = a_mem_valid ? 0 : gap + 1;
            end
            pv = a_mem_valid; paddr = a_mem_addr; pwd = a_mem_wdata; pws = a_mem_wstrb; pins = a_mem_instr;
        end
    end

    typedef struct {
        string       name;
        logic [1:0]  req;
        logic        instr;
        logic [31:0] a0, a1, wd;
        logic [3:0]  ws;
        int          lat;
        logic [31:0] rd;
        logic        ewin;
        int          eidx;
        logic [31:0] erd;
        logic        eterr;
    } vec_t;

    function automatic vec_t mkv(input string n, input logic [1:0] rq, input logic ins,
                                 input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd,
                                 input logic [3:0] ws, input int lat, input logic [31:0] rd,
                                 input logic ew, input int ei, input logic [31:0] er, input logic et);
        vec_t v;
        v.name = n; v.req = rq; v.instr = ins; v.a0 = a0; v.a1 = a1; v.wd = wd; v.ws = ws;
        v.lat = lat; v.rd = rd; v.ewin = ew; v.eidx = ei; v.erd = er; v.eterr = et;
        return v;
    endfunction

    task automatic idle_inputs();
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // m1 sees inverted write data so the two requesters are always distinguishable.
    task automatic run_vec(input vec_t v);
        logic        started = 0, got = 0;
        int          idx = 0;
        logic [31:0] ea, ew;
        ea = v.ewin ? v.a1 : v.a0;
        ew = v.ewin ? ~v.wd : v.wd;
        rsp_lat = v.lat; rsp_data = v.rd;
        @(posedge clk); #1;
        m0_valid = v.req[0]; m0_instr = v.instr; m0_addr = v.a0; m0_wdata = v.wd;  m0_wstrb = v.ws;
        m1_valid = v.req[1]; m1_instr = v.instr; m1_addr = v.a1; m1_wdata = ~v.wd; m1_wstrb = v.ws;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (a_mem_valid) begin
                if (!started) begin
                    started = 1;
                    chk({v.name, "_grant"}, a_grant, v.ewin);
                    chk({v.name, "_addr"}, a_mem_addr, ea);
                    chk({v.name, "_wdata"}, a_mem_wdata, ew);
                    chk({v.name, "_wstrb"}, a_mem_wstrb, v.ws);
                    chk({v.name, "_instr"}, a_mem_instr, v.instr);
                end
                if (a_m0_ready || a_m1_ready) begin
                    got = 1;
                    chk({v.name, "_idx"}, idx, v.eidx);
                    chk({v.name, "_who"}, a_m1_ready, v.ewin);
                    chk({v.name, "_rdata"}, v.ewin ? a_m1_rdata : a_m0_rdata, v.erd);
                    chk({v.name, "_loser_rdata"}, v.ewin ? a_m0_rdata : a_m1_rdata, 0);
                end
                idx++;
            end
        end
        if (!got) bound_fail(v.name);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({v.name, "_terr"}, a_terr, v.eterr);
        chk({v.name, "_mv_low"}, a_mem_valid, 0);
        repeat (2) @(posedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        int          ga[4], gb[4];
        int          na, nb, hi, seen;
        logic        pa, pb, got, gb_after_ok;
        logic        gb_after;

        vecs[0] = mkv("m0_rd",  2'b01, 0, 32'h100, 32'h0,   32'h0,        4'b0000, 3,   32'hCAFEF00D, 0, 3, 32'hCAFEF00D, 0);
        vecs[1] = mkv("m1_wr",  2'b10, 0, 32'h0,   32'h204, 32'hEDCBA987, 4'b0101, 4,   32'h55,       1, 4, 32'h55,       0);
        vecs[2] = mkv("both_a", 2'b11, 0, 32'h300, 32'h400, 32'h0,        4'b0000, 2,   32'h11111111, 0, 2, 32'h11111111, 0);
        vecs[3] = mkv("both_b", 2'b11, 0, 32'h310, 32'h410, 32'h0,        4'b0000, 1,   32'h22222222, 1, 1, 32'h22222222, 0);
        vecs[4] = mkv("ifetch", 2'b01, 1, 32'h500, 32'h0,   32'h0,        4'b0000, 5,   32'h13,       0, 5, 32'h13,       0);
        vecs[5] = mkv("wd_tie", 2'b01, 0, 32'h600, 32'h0,   32'h0,        4'b0000, 7,   32'h77777777, 0, 7, 32'h77777777, 0);
        vecs[6] = mkv("wd_exp", 2'b10, 0, 32'h0,   32'h700, 32'h0,        4'b0000, 100, 32'h99999999, 1, 7, ERR,          1);

        // Reset values, with a request pending to show reset dominates.
        m0_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", a_mem_valid, 0);
        chk("rst_grant", a_grant, 1);
        chk("rst_terr", a_terr, 0);
        chk("rst_ready", {a_m0_ready, a_m1_ready}, 0);
        chk("rst_addr", a_mem_addr, 0);
        chk("rst_wdata", a_mem_wdata, 0);
        chk("rst_wstrb", a_mem_wstrb, 0);
        chk("rst_instr", a_mem_instr, 0);
        do_reset();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Sticky error survives idle time and clears only on reset.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("terr_sticky", a_terr, 1);
        do_reset();
        @(negedge clk);
        chk("terr_cleared", a_terr, 0);

        // Grant order with both requesters permanently busy: RR alternates,
        // fixed sticks to m0 until m0 goes quiet.
        rsp_lat = 1; rsp_data = 32'h0;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'h800; m1_valid = 1; m1_addr = 32'h900;
        na = 0; nb = 0; pa = 0; pb = 0; gb_after_ok = 0; gb_after = 0;
        for (int c = 0; c < 200 && !gb_after_ok; c++) begin
            @(negedge clk);
            if (a_mem_valid && !pa && na < 4) begin ga[na] = a_grant; na++; end
            if (b_mem_valid && !pb) begin
                if (nb < 4) begin gb[nb] = b_grant; nb++; end
                else begin gb_after = b_grant; gb_after_ok = 1; end
            end
            pa = a_mem_valid; pb = b_mem_valid;
            if (nb == 4 && m0_valid) begin @(posedge clk); #1 m0_valid = 0; end
        end
        if (na == 4 && nb == 4 && gb_after_ok) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_order_%0d", i), ga[i], i % 2);
                chk($sformatf("fixed_order_%0d", i), gb[i], 0);
            end
            chk("fixed_after_m0_idle", gb_after, 1);
        end else bound_fail("grant_order");
        idle_inputs();
        do_reset();

        // Reset while BUSY, landing on the very cycle mem_ready arrives.
        rsp_lat = 3; rsp_data = 32'h12121212;
        @(posedge clk); #1;
        m0_valid = 1; m0_addr = 32'hA00;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (a_mem_valid) got = 1;
        end
        if (!got) bound_fail("rst_busy_grant");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("rst_busy_mem_ready_seen", mem_ready, 1);
        chk("rst_busy_no_ready", {a_m0_ready, a_m1_ready}, 0);
        @(posedge clk); #1;
        reset = 0; m0_valid = 0;
        rsp_lat = 2; rsp_data = 32'hA5A5A5A5;
        m1_valid = 1; m1_addr = 32'hB00;
        @(negedge clk);
        chk("rst_busy_mv_low", a_mem_valid, 0);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (a_m0_ready) chk("post_rst_m0_ready", a_m0_ready, 0);
            if (a_m1_ready) begin
                got = 1;
                chk("post_rst_addr", a_mem_addr, 32'hB00);
                chk("post_rst_rdata", a_m1_rdata, 32'hA5A5A5A5);
            end
        end
        if (!got) bound_fail("post_rst_m1");
        @(posedge clk); #1 idle_inputs();
        repeat (3) @(posedge clk);

        // Granted requester abandons mid-BUSY: access runs to mem_ready, no pulse, no reissue.
        rsp_lat = 4; rsp_data = 32'h3C3C3C3C;
        @(posedge clk); #1;
        m1_valid = 1; m1_addr = 32'hC00;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (a_mem_valid) got = 1;
        end
        if (!got) bound_fail("drop_grant");
        @(posedge clk); #1 m1_valid = 0;
        hi = 1; seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_mem_valid) hi++;
            if (a_m0_ready || a_m1_ready) seen++;
        end
        chk("drop_busy_cycles", hi, 5);
        chk("drop_no_ready", seen, 0);

        // Randomized traffic against a request-level model.
        do_reset();
        begin
            logic        act[2], dn[2], ins[2];
            logic [31:0] ad[2], wd[2];
            logic [3:0]  ws[2];
            logic [1:0]  pv;
            logic        last_win, terr_m, inbusy, owner, win;
            int          bidx, cur_lat, r;
            logic [31:0] cur_data;
            for (int i = 0; i < 2; i++) begin act[i] = 0; dn[i] = 0; ins[i] = 0; ad[i] = 0; wd[i] = 0; ws[i] = 0; end
            pv = 0; last_win = 1; terr_m = 0; inbusy = 0; owner = 0; bidx = 0; cur_lat = 0; cur_data = 0;
            r = $urandom_range(0, 9);
            rsp_lat = (r < 7) ? r + 1 : ((r == 7) ? TO - 1 : TO + 4);
            rsp_data = $urandom;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if (act[i] && dn[i]) begin
                        act[i] = 0; dn[i] = 0;
                    end else if (!act[i] && $urandom_range(0, 3) == 0) begin
                        act[i] = 1; ins[i] = 1'($urandom_range(0, 1));
                        ad[i] = $urandom & 32'hFFFF_FFFC; wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
                    end
                end
                m0_valid = act[0]; m0_instr = ins[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_wstrb = ws[0];
                m1_valid = act[1]; m1_instr = ins[1]; m1_addr = ad[1]; m1_wdata = wd[1]; m1_wstrb = ws[1];
                @(negedge clk);
                chk("rand_terr", a_terr, terr_m);
                if (a_mem_valid && !inbusy) begin
                    win = (pv == 2'b11) ? !last_win : (pv == 2'b10);
                    chk("rand_grant", a_grant, win);
                    chk("rand_addr", a_mem_addr, ad[win]);
                    chk("rand_wdata", a_mem_wdata, wd[win]);
                    chk("rand_wstrb", a_mem_wstrb, ws[win]);
                    chk("rand_instr", a_mem_instr, ins[win]);
                    owner = win; last_win = win; inbusy = 1; bidx = 0;
                    cur_lat = rsp_lat; cur_data = rsp_data;
                end
                if (inbusy) begin
                    if (a_m0_ready || a_m1_ready) begin
                        chk("rand_who", a_m1_ready, owner);
                        chk("rand_idx", bidx, (cur_lat < TO - 1) ? cur_lat : TO - 1);
                        chk("rand_rdata", owner ? a_m1_rdata : a_m0_rdata, (cur_lat <= TO - 1) ? cur_data : ERR);
                        if (cur_lat > TO - 1) terr_m = 1;
                        dn[owner] = 1; inbusy = 0;
                        r = $urandom_range(0, 9);
                        rsp_lat = (r < 7) ? r + 1 : ((r == 7) ? TO - 1 : TO + 4);
                        rsp_data = $urandom;
                    end else if (bidx >= TO - 1) begin
                        bound_fail("rand_completion");
                        dn[owner] = 1; inbusy = 0;
                    end
                    bidx++;
                end
                pv = {m1_valid, m0_valid};
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
